multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle RISC-V control unit: the sequential successor of the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives per-cycle datapath enables from a Moore state machine. It stalls on a memory ready handshake and traps illegal opcodes. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- ALUCTRL_W, 3, width of alu_control; must be ≥3; bits above [2:0] are driven 0
- ILLEGAL_HALT, 1, 1: an illegal opcode enters HALT; 0: an illegal opcode is retired as a NOP
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op  in  7  opcode, from the instruction register
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register and OldPC load enable
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- reg_write  out  1  register file write enable
- alu_control  out  ALUCTRL_W  ALU operation
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state, for debug and verification

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR1=11, JALR2=12, HALT=13.
- Any output not listed for a state below is 0.
- FETCH
  - Outputs: adr_src=0, a=00, b=10, aluop=00, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - Outputs: a=01, b=01, aluop=00.
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 0000000 → FETCH with retire=1 (NOP).
  - Any other op is illegal: → HALT if ILLEGAL_HALT=1, else → FETCH with retire=1. In both cases illegal is set.
- MEMADR
  - Outputs: a=10, b=01, aluop=00.
  - → MEMREAD if op[5]=0, else → MEMWRITE.
- MEMREAD
  - Outputs: adr_src=1.
  - Holds until mem_ready=1, then → MEMWB.
- MEMWB
  - Outputs: result_src=01, reg_write=1, retire=1.
  - → FETCH.
- MEMWRITE
  - Outputs: adr_src=1, mem_write=1.
  - mem_write is held until mem_ready=1; in that cycle retire=1 and the next state is FETCH.
- EXECR
  - Outputs: a=10, b=00, aluop=10.
  - → ALUWB.
- EXECI
  - Outputs: a=10, b=01, aluop=10.
  - → ALUWB.
- ALUWB
  - Outputs: result_src=00, reg_write=1, retire=1.
  - → FETCH.
- BRANCH
  - Outputs: a=10, b=00, aluop=01, result_src=00.
  - pc_write = zero if funct3=000 (beq), ~zero if funct3=001 (bne).
  - Other funct3 values: no PC write.
  - retire=1; → FETCH.
- JAL
  - Outputs: a=01, b=10, aluop=00, result_src=00, pc_write=1.
  - → ALUWB.
- HALT
  - All enables are 0.
  - Leaves only on reset.
- imm_src is combinational from op: loads, OP-IMM and jalr → 00; stores → 01; branches → 10; jal → 11; anything else → 00.
- ALU decoder, combinational:
  - aluop=00 → 000 (add); aluop=01 → 001 (sub).
  - aluop=10, by funct3:
    - 000 → 001 (sub) if op[5]&funct7b5, else 000 (add)
    - 010 → 101 (slt)
    - 110 → 011 (or)
    - 111 → 010 (and)
    - any other funct3 → 000
  - aluop=11 → 000.

## Timing
- Only the state register and illegal are registered; all outputs are combinational from state and inputs.
- Reset (synchronous, active-high) sets state=FETCH and illegal=0. Reset takes precedence over every transition, including mid-access with mem_ready low and while in HALT.
- Output values during and after reset are the FETCH values, with ir_write/pc_write following mem_ready. retire=0 and illegal=0.
- Cycle counts with mem_ready tied to 1:
  - R-type, I-type, jal: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - NOP: 2 cycles
- Each cycle with mem_ready low adds one cycle in FETCH, MEMREAD or MEMWRITE.
- illegal rises the cycle after the DECODE that detects the illegal opcode.

## Configuration
- MC_CTRL_JALR_EN defined: op 1100111 is decoded. The sequence is DECODE → JALR1 → JALR2 → ALUWB.
  - JALR1 outputs: a=10, b=01, aluop=00.
  - JALR2 outputs: result_src=00, pc_write=1, a=01, b=10, aluop=00.
  - JALR takes 5 cycles.
- MC_CTRL_JALR_EN undefined: op 1100111 is illegal. JALR1 and JALR2 are unreachable.

## Test plan
- reset=1 during MEMREAD with mem_ready=0 → next cycle state=0, ir_write=0, pc_write=0, illegal=0.
- add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 → states 0,1,6,8; alu_control=000 in EXECR; reg_write=1 and retire=1 in ALUWB.
- lw with mem_ready low for 3 cycles in MEMREAD → MEMREAD lasts 4 cycles; MEMWB asserts result_src=01 and reg_write=1; total 8 cycles.
- beq with zero=1 → pc_write=1 in BRANCH; bne with zero=1 → pc_write=0; retire=1 in both.
- op 1111111 with ILLEGAL_HALT=1 → state=13, illegal=1, all enables 0 for 10 cycles; reset recovers. With ILLEGAL_HALT=0 → retire=1, back to FETCH, illegal=1.
- jalr under MC_CTRL_JALR_EN → states 0,1,11,12,8 with pc_write=1 in JALR2; without the macro → illegal path.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional jalr support is compiled in when MC_CTRL_JALR_EN is defined.
module multicycle_controller #(
  parameter int ALUCTRL_W    = 3,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic                 reg_write,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 retire,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR1 = 4'd11,
    S_JALR2 = 4'd12, S_HALT = 4'd13
  } state_t;

  state_t     state_q, state_n, cur;
  logic       illegal_q;
  logic       op_legal;
  logic [1:0] aluop;
  logic [2:0] alu_op3;

  // While reset is held the outputs already present the FETCH view.
  assign cur     = reset ? S_FETCH : state_q;
  assign state   = cur;
  assign illegal = illegal_q & ~reset;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1100011, 7'b1101111, 7'b0000000: op_legal = 1'b1;
`ifdef MC_CTRL_JALR_EN
      7'b1100111: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      illegal_q <= illegal_q | ((state_q == S_DECODE) && !op_legal);
    end
  end

  always_comb begin
    state_n    = cur;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    retire     = 1'b0;
    aluop      = 2'b00;
    case (cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_n = S_MEMADR;
          7'b0110011: state_n = S_EXECR;
          7'b0010011: state_n = S_EXECI;
          7'b1100011: state_n = S_BRANCH;
          7'b1101111: state_n = S_JAL;
          7'b0000000: begin
            state_n = S_FETCH;
            retire  = 1'b1;
          end
`ifdef MC_CTRL_JALR_EN
          7'b1100111: state_n = S_JALR1;
`endif
          default: begin
            if (ILLEGAL_HALT) begin
              state_n = S_HALT;
            end else begin
              state_n = S_FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
        state_n   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        aluop     = 2'b01;
        pc_write  = (funct3 == 3'b000) ? zero : ((funct3 == 3'b001) ? ~zero : 1'b0);
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = S_JALR2;
      end
      S_JALR2: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  always_comb begin
    alu_op3 = 3'b000;
    case (aluop)
      2'b01: alu_op3 = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_op3 = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_op3 = 3'b101;
          3'b110:  alu_op3 = 3'b011;
          3'b111:  alu_op3 = 3'b010;
          default: alu_op3 = 3'b000;
        endcase
      end
      default: alu_op3 = 3'b000;
    endcase
    alu_control      = '0;
    alu_control[2:0] = alu_op3;
  end

endmodule
